// File: rtl/vga_mode_sequencer_if.sv
// Signal bundle between the TT pins / VGA timing generator and the mode sequencer.
// The bench or top level uses the master side; the sequencer uses the slave side.
interface vga_mode_sequencer_if #(
  parameter int unsigned MODE_W = 2
) ();
  logic              btn_next;
  logic              auto_en;
  logic              frame_start;
  logic [MODE_W-1:0] mode_sel;
  logic              mode_update;
  logic              pending;

  modport master (
    output btn_next,
    output auto_en,
    output frame_start,
    input  mode_sel,
    input  mode_update,
    input  pending
  );

  modport slave (
    input  btn_next,
    input  auto_en,
    input  frame_start,
    output mode_sel,
    output mode_update,
    output pending
  );
endinterface

// File: rtl/vga_mode_sequencer.sv
// Pattern-mode controller: debounced push-button and auto-cycle timer produce
// advance requests that are applied to mode_sel only at frame boundaries.
module vga_mode_sequencer #(
  parameter int unsigned NUM_MODES       = 4,
  parameter int unsigned MODE_W          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DB_W            = 16,
  parameter int unsigned AUTO_FRAMES     = 120
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vga_mode_sequencer_if.slave     bus
);

  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]        FR_LAST   = 8'(AUTO_FRAMES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              db_level_q, db_level_d;
  logic              db_prev_q, db_prev_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic [MODE_W-1:0] mode_sel_q, mode_sel_d;
  logic              mode_update_q, mode_update_d;

  logic btn_s;
  logic man_req;
  logic auto_req;
  logic req;
  logic advance;

  always_comb begin
    sync1_d       = bus.btn_next;
    sync2_d       = sync1_q;
    btn_s         = sync2_q;
    db_level_d    = db_level_q;
    db_cnt_d      = '0;
    db_prev_d     = db_level_q;
    state_d       = state_q;
    advance       = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    mode_sel_d    = mode_sel_q;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    if (btn_s != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = btn_s;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    man_req  = db_level_q & ~db_prev_q;
    auto_req = bus.frame_start & bus.auto_en & (frame_cnt_q == FR_LAST);
    req      = man_req | auto_req;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (bus.frame_start) advance = 1'b1;
          else                 state_d = ARMED;
        end
      end
      ARMED: begin
        if (bus.frame_start) begin
          advance = 1'b1;
          state_d = IDLE;
        end
      end
    endcase

    if (!bus.auto_en || advance) begin
      frame_cnt_d = '0;
    end else if (bus.frame_start) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    if (advance) begin
      mode_sel_d = (mode_sel_q == MODE_LAST) ? '0 : mode_sel_q + MODE_W'(1);
    end
    mode_update_d = advance;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      db_level_q    <= 1'b0;
      db_prev_q     <= 1'b0;
      db_cnt_q      <= '0;
      frame_cnt_q   <= '0;
      mode_sel_q    <= '0;
      mode_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      db_level_q    <= db_level_d;
      db_prev_q     <= db_prev_d;
      db_cnt_q      <= db_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      mode_sel_q    <= mode_sel_d;
      mode_update_q <= mode_update_d;
    end
  end

  assign bus.mode_sel    = mode_sel_q;
  assign bus.mode_update = mode_update_q;
  assign bus.pending     = (state_q == ARMED);

endmodule

// File: tb/tb_vga_mode_sequencer.sv
// Self-checking bench for vga_mode_sequencer: directed scenarios plus random
// button/auto/frame stimulus against a queue-based reference model.
module tb_vga_mode_sequencer;
  localparam int NM = 3;
  localparam int D  = 4;
  localparam int AF = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_mode_sequencer_if #(.MODE_W(2)) bus ();

  vga_mode_sequencer #(
    .NUM_MODES      (NM),
    .MODE_W         (2),
    .DEBOUNCE_CYCLES(D),
    .DB_W           (16),
    .AUTO_FRAMES    (AF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;
  int expq[$];

  // Reference model state: values that hold after the most recent clock edge.
  logic m_s1, m_s2, m_lvl, m_prev, m_armed, m_upd;
  int   m_fcnt, m_mode;
  logic hist[$];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_lvl = 0; m_prev = 0; m_armed = 0; m_upd = 0;
    m_fcnt = 0; m_mode = 0;
    hist.delete();
    expq.delete();
  endtask

  // One clock cycle: drive inputs, predict from the rules, commit at the edge.
  task automatic cyc(input logic b, input logic a, input logic f);
    logic bs, man, aut, req, adv, n_armed, n_lvl;
    int n_mode, n_fcnt;
    bus.btn_next = b; bus.auto_en = a; bus.frame_start = f;
    bs  = m_s2;
    man = m_lvl && !m_prev;
    aut = f && a && (m_fcnt == AF - 1);
    req = man || aut;
    adv = f && (m_armed || req);
    n_armed = m_armed ? !f : (req && !f);
    n_mode  = adv ? (m_mode + 1) % NM : m_mode;
    n_fcnt  = (!a || adv) ? 0 : (f ? (m_fcnt + 1) % 256 : m_fcnt);
    n_lvl   = m_lvl;
    if (bs == m_lvl) hist.delete();
    else begin
      hist.push_back(bs);
      if (hist.size() == D) begin
        n_lvl = !m_lvl;
        hist.delete();
      end
    end
    @(posedge clk);
    m_prev = m_lvl; m_lvl = n_lvl;
    m_s2 = m_s1; m_s1 = b;
    m_armed = n_armed; m_mode = n_mode; m_upd = adv; m_fcnt = n_fcnt;
    if (adv) expq.push_back(n_mode);
    #1;
  endtask

  task automatic frame(input logic b, input logic a, input int gap);
    repeat (gap) cyc(b, a, 1'b0);
    cyc(b, a, 1'b1);
  endtask

  task automatic press();
    repeat (8) cyc(1'b1, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_mode_sel", bus.mode_sel, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_mode_update", bus.mode_update, 0);
    model_reset();
    bus.btn_next = 0; bus.auto_en = 0; bus.frame_start = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: pops the expected mode whenever the DUT signals an update.
  always @(negedge clk) begin
    if (run && rst_n) begin
      chk("pending", bus.pending, m_armed);
      chk("mode_update", bus.mode_update, m_upd);
      if (bus.mode_update) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_pop: mode_update with no expected entry, mode_sel=%0d", bus.mode_sel);
        end else begin
          chk("sb_mode_sel", bus.mode_sel, expq.pop_front());
        end
      end
      chk("mode_sel_hold", bus.mode_sel, m_mode);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, run_len, seg;
    logic b, a;
    bus.btn_next = 0; bus.auto_en = 0; bus.frame_start = 0;
    model_reset();
    #2;
    chk("init_mode_sel", bus.mode_sel, 0);
    chk("init_pending", bus.pending, 0);
    chk("init_mode_update", bus.mode_update, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;

    repeat (10) frame(1'b0, 1'b0, 5);
    chk("idle_frames_mode", bus.mode_sel, 0);

    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    repeat (8) cyc(1'b0, 1'b0, 1'b0);
    chk("glitch_pending", bus.pending, 0);
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    chk("press_armed", bus.pending, 1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("first_advance", bus.mode_sel, 1);
    chk("first_update", bus.mode_update, 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("update_one_cycle", bus.mode_update, 0);

    repeat (3) press();
    cyc(1'b0, 1'b0, 1'b1);
    chk("coalesce", bus.mode_sel, 2);
    for (int k = 1; k <= 3; k++) begin
      press();
      cyc(1'b0, 1'b0, 1'b1);
      chk("wrap_seq", bus.mode_sel, (2 + k) % NM);
    end

    press();
    chk("pre_reset_armed", bus.pending, 1);
    chk("pre_reset_mode", bus.mode_sel, 2);
    do_reset();
    repeat (5) frame(1'b0, 1'b0, 5);
    chk("post_reset_mode", bus.mode_sel, 0);

    for (int k = 1; k <= 9; k++) begin
      frame(1'b0, 1'b1, 4);
      if (k % 3 == 0) chk("auto_seq", bus.mode_sel, (k / 3) % NM);
    end
    repeat (4) frame(1'b0, 1'b1, 4);
    repeat (6) frame(1'b0, 1'b0, 4);
    chk("auto_off_hold", bus.mode_sel, 1);

    repeat (6) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("same_cycle_adv", bus.mode_sel, 2);
    repeat (10) cyc(1'b0, 1'b0, 1'b0);

    frame(1'b0, 1'b1, 4);
    repeat (6) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    chk("manual_in_auto", bus.mode_sel, 0);
    frame(1'b0, 1'b1, 10);
    frame(1'b0, 1'b1, 4);
    chk("auto_restart_f4", bus.mode_sel, 0);
    frame(1'b0, 1'b1, 4);
    chk("auto_restart_f5", bus.mode_sel, 1);

    b = 0; a = 0; run_len = 0; seg = 0;
    gap = $urandom_range(3, 20);
    for (int i = 0; i < 3000; i++) begin
      if (run_len == 0) begin
        b = $urandom_range(0, 1);
        run_len = $urandom_range(1, 12);
      end
      run_len--;
      if (seg == 0) begin
        a = $urandom_range(0, 1);
        seg = $urandom_range(20, 200);
      end
      seg--;
      if (gap == 0) begin
        cyc(b, a, 1'b1);
        gap = $urandom_range(3, 20);
      end else begin
        cyc(b, a, 1'b0);
        gap--;
      end
      if (i == 1500) begin
        do_reset();
        b = 1;
      end
    end

    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    chk("sb_drain", expq.size(), 0);
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
